// File: rtl/oled_intr_arbiter.sv
// ---------------------------------------------------------------------------
// oled_intr_arbiter
// Round-robin arbiter that shares the OLED command interpreter's interrupt
// entry (intr / i_adr) among NREQ requesters. Each requester posts a request
// with the program-memory address of its command routine. The arbiter launches
// one routine at a time when the interpreter is idle at a NULL command. It then
// tracks that routine to completion and reports grant and done per requester.
//
// Parameters
//   NREQ      : number of requesters (2..8)
//   ADR_W     : routine address width (interpreter p_adr width)
//   WD_CYCLES : watchdog limit in cycles (only with OLED_ARB_WATCHDOG_EN)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [NREQ]        per-requester request (each high cycle counts)
//   req_adr in   [NREQ*ADR_W]  routine address, slice i for requester i
//   ready   in   interpreter idle at NULL command
//   intr    out  interrupt request to interpreter
//   i_adr   out  [ADR_W]  interrupt routine address to interpreter
//   grant   out  [NREQ]   one-hot pulse when a routine is launched
//   done    out  [NREQ]   one-hot pulse when the launched routine finished
//   busy    out  high while a routine is being issued or is running
//   err     out  pulse on watchdog abort (always 0 without the watchdog)
//
// Optional feature macro: OLED_ARB_WATCHDOG_EN
//   When defined, a cycle counter aborts a stuck ISSUE or RUN phase after
//   WD_CYCLES cycles. It raises err and done for the current requester.
// ---------------------------------------------------------------------------
module oled_intr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADR_W     = 8,
    parameter int unsigned WD_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ADR_W-1:0] req_adr,
    input  logic                  ready,
    output logic                  intr,
    output logic [ADR_W-1:0]      i_adr,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Elaboration-time guard on the supported parameter range.
    if (NREQ < 2 || NREQ > 8 || ADR_W < 1 || WD_CYCLES < 1) begin : g_bad_param
        $error("oled_intr_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic [ADR_W-1:0] adr_q [NREQ];
    logic [ADR_W-1:0] adr_d [NREQ];
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic             intr_q, intr_d;
    logic [ADR_W-1:0] i_adr_q, i_adr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             win_found_c;
    logic [IDX_W-1:0] win_idx_c;
    logic [ADR_W-1:0] req_slice_c [NREQ];

`ifdef OLED_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Split the flat address bus into one slice per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_slice_c[g] = req_adr[g*ADR_W +: ADR_W];
    end

    // Round-robin search: first pending index after last, wrapping modulo NREQ.
    always_comb begin
        int unsigned probe;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        probe       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            probe = 32'(last_q) + k;
            if (probe >= NREQ) begin
                probe = probe - NREQ;
            end
            if (!win_found_c && pending_q[IDX_W'(probe)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(probe);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        adr_d     = adr_q;
        last_d    = last_q;
        cur_d     = cur_q;
        intr_d    = intr_q;
        i_adr_d   = i_adr_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = 1'b0;
`ifdef OLED_ARB_WATCHDOG_EN
        wd_cnt_d  = '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (ready && win_found_c) begin
                    state_d              = S_ISSUE;
                    intr_d               = 1'b1;
                    i_adr_d              = adr_q[win_idx_c];
                    grant_d              = NREQ'(1) << win_idx_c;
                    pending_d[win_idx_c] = 1'b0;
                    last_d               = win_idx_c;
                    cur_d                = win_idx_c;
                end
            end
            S_ISSUE: begin
                // The interpreter has taken the jump once ready goes low.
                if (!ready) begin
                    intr_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // ready returning means the routine hit its terminating NULL.
                if (ready) begin
                    done_d  = NREQ'(1) << cur_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef OLED_ARB_WATCHDOG_EN
        // Counter restarts on every state change; abort when it hits the limit.
        if (state_q != S_IDLE && state_d == state_q) begin
            if ((32'(wd_cnt_q) + 32'd1) >= WD_CYCLES) begin
                intr_d  = 1'b0;
                err_d   = 1'b1;
                done_d  = NREQ'(1) << cur_q;
                state_d = S_IDLE;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
`endif

        // Requests are applied last so a request on the winner's own grant edge
        // keeps it pending with the fresh address.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                pending_d[i] = 1'b1;
                adr_d[i]     = req_slice_c[i];
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                adr_q[i] <= '0;
            end
            last_q    <= IDX_W'(NREQ - 1);
            cur_q     <= '0;
            intr_q    <= 1'b0;
            i_adr_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef OLED_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                adr_q[i] <= adr_d[i];
            end
            last_q    <= last_d;
            cur_q     <= cur_d;
            intr_q    <= intr_d;
            i_adr_q   <= i_adr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef OLED_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
`endif
        end
    end

    assign intr  = intr_q;
    assign i_adr = i_adr_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_oled_intr_arbiter.sv
// Bench for oled_intr_arbiter: a small interpreter model drives ready, a
// reference model predicts grant/done/err events into a queue, and a monitor
// compares the DUT against it on the falling edge.
module tb_oled_intr_arbiter;

    localparam int NREQ  = 4;
    localparam int ADR_W = 8;
    localparam int WD    = 16;
`ifdef OLED_ARB_WATCHDOG_EN
    localparam int SINGLE_LOW = 12;
`else
    localparam int SINGLE_LOW = 20;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*ADR_W-1:0] req_adr;
    logic                  ready;
    logic                  intr;
    logic [ADR_W-1:0]      i_adr;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;

    always #5 clk = ~clk;

    oled_intr_arbiter #(
        .NREQ      (NREQ),
        .ADR_W     (ADR_W),
        .WD_CYCLES (WD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_adr (req_adr),
        .ready   (ready),
        .intr    (intr),
        .i_adr   (i_adr),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    typedef struct {
        logic [NREQ-1:0]  grant;
        logic [NREQ-1:0]  done;
        logic             err;
        logic [ADR_W-1:0] adr;
    } ev_t;

    ev_t exp_q[$];
    int  gorder[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: phase 0 = free, 1 = interrupt posted, 2 = routine running.
    int               m_phase = 0;
    bit               m_pend [NREQ];
    logic [ADR_W-1:0] m_adr  [NREQ];
    int               m_last = NREQ - 1;
    int               m_cur  = 0;
    int               m_wd   = 0;
    logic [ADR_W-1:0] m_iadr = '0;

    // Interpreter model state.
    bit manual     = 1'b1;
    bit ext_drop   = 1'b0;
    int low_left   = 0;
    int jump_delay = 0;
    bit mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) begin
            if (m_pend[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wd_tick();
`ifdef OLED_ARB_WATCHDOG_EN
        ev_t e;
        m_wd++;
        if (m_wd >= WD) begin
            e.grant = '0;
            e.done  = NREQ'(1) << m_cur;
            e.err   = 1'b1;
            e.adr   = m_iadr;
            exp_q.push_back(e);
            m_phase = 0;
            m_wd    = 0;
        end
`endif
    endtask

    // Applies the arbitration rules to the inputs seen at this rising edge.
    task automatic model_step();
        ev_t e;
        if (rst) begin
            m_phase = 0;
            m_last  = NREQ - 1;
            m_cur   = 0;
            m_wd    = 0;
            m_iadr  = '0;
            for (int i = 0; i < NREQ; i++) begin
                m_pend[i] = 1'b0;
                m_adr[i]  = '0;
            end
            return;
        end
        case (m_phase)
            0: begin
                if (ready && any_pending()) begin
                    int w;
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (w < 0 && m_pend[c]) w = c;
                    end
                    e.grant = NREQ'(1) << w;
                    e.done  = '0;
                    e.err   = 1'b0;
                    e.adr   = m_adr[w];
                    exp_q.push_back(e);
                    m_iadr    = m_adr[w];
                    m_pend[w] = 1'b0;
                    m_last    = w;
                    m_cur     = w;
                    m_phase   = 1;
                    m_wd      = 0;
                end
            end
            1: begin
                if (!ready) begin
                    m_phase = 2;
                    m_wd    = 0;
                end else begin
                    wd_tick();
                end
            end
            2: begin
                if (ready) begin
                    e.grant = '0;
                    e.done  = NREQ'(1) << m_cur;
                    e.err   = 1'b0;
                    e.adr   = m_iadr;
                    exp_q.push_back(e);
                    m_phase = 0;
                end else begin
                    wd_tick();
                end
            end
            default: m_phase = 0;
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                m_pend[i] = 1'b1;
                m_adr[i]  = req_adr[i*ADR_W +: ADR_W];
            end
        end
    endtask

    // Interpreter: jumps on intr after a short delay, runs a random-length routine,
    // and occasionally drops ready while idle.
    task automatic drive_interp();
        if (manual) return;
        if (low_left > 0) begin
            low_left--;
            if (low_left == 0) ready = 1'b1;
        end else if (ext_drop) begin
            ext_drop = 1'b0;
            ready    = 1'b1;
        end else if (intr && ready) begin
            if (jump_delay > 0) begin
                jump_delay--;
            end else begin
                ready      = 1'b0;
                low_left   = int'($urandom_range(20, 1));
                jump_delay = int'($urandom_range(2, 0));
            end
        end else if (!intr && ready && $urandom_range(15, 0) == 0) begin
            ready    = 1'b0;
            ext_drop = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        drive_interp();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst      = 1'b0;
        low_left = 0;
        ext_drop = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = 0;
        while ((m_phase != 0 || any_pending() || exp_q.size() != 0) && b < budget) begin
            step();
            b++;
        end
        if (b >= budget) timeout_fail(name);
    endtask

    // Monitor: per-cycle level checks plus event scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            check("intr", 32'(intr), 32'(m_phase == 1));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("i_adr", 32'(i_adr), 32'(m_iadr));
            if (grant != '0 || done != '0 || err) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant[i]) gorder.push_back(i);
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got grant=%b done=%b err=%b, required no event",
                             grant, done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_grant", 32'(grant), 32'(e.grant));
                    check("ev_done", 32'(done), 32'(e.done));
                    check("ev_err", 32'(err), 32'(e.err));
                    if (e.grant != '0) check("ev_adr", 32'(i_adr), 32'(e.adr));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_event: got no event, required grant=%b done=%b err=%b",
                         e.grant, e.done, e.err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [NREQ-1:0] done_seen;
        int b;

        rst = 1'b1; req = '0; req_adr = '0; ready = 1'b0; manual = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_i_adr", 32'(i_adr), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        mon_en = 1'b1;

        // Single request from requester 2.
        ready = 1'b1;
        step();
        req_adr[2*ADR_W +: ADR_W] = 8'h40;
        req = 4'b0100;
        step();
        req = '0;
        check("single_no_early_intr", 32'(intr), 32'd0);
        step();
        check("single_intr", 32'(intr), 32'd1);
        check("single_iadr", 32'(i_adr), 32'h40);
        check("single_grant", 32'(grant), 32'b0100);
        ready = 1'b0;
        step();
        check("single_intr_fall", 32'(intr), 32'd0);
        check("single_busy_run", 32'(busy), 32'd1);
        repeat (SINGLE_LOW - 1) step();
        check("single_no_early_done", 32'(done), 32'd0);
        ready = 1'b1;
        step();
        check("single_done", 32'(done), 32'b0100);
        check("single_busy_off", 32'(busy), 32'd0);
        step();
        check("single_done_pulse", 32'(done), 32'd0);

        // Fairness from reset pointer, with a repeat request from requester 0.
        do_reset();
        manual = 1'b0; ready = 1'b1; jump_delay = 0;
        gorder.delete();
        for (int i = 0; i < NREQ; i++) req_adr[i*ADR_W +: ADR_W] = 8'(8'h10 + i);
        req = '1;
        step();
        req = '0;
        b = 0;
        while (!(m_cur == 1 && m_phase != 0) && b < 2000) begin
            step();
            b++;
        end
        if (b >= 2000) timeout_fail("fair_wait_grant1");
        req_adr[0 +: ADR_W] = 8'h20;
        req = 4'b0001;
        step();
        req = '0;
        drain("fair_drain", 3000);
        step();
        check("fair_count", 32'(gorder.size()), 32'd5);
        if (gorder.size() == 5) begin
            check("fair_0", 32'(gorder[0]), 32'd0);
            check("fair_1", 32'(gorder[1]), 32'd1);
            check("fair_2", 32'(gorder[2]), 32'd2);
            check("fair_3", 32'(gorder[3]), 32'd3);
            check("fair_4", 32'(gorder[4]), 32'd0);
        end

        // Startup: interpreter not ready for 500 cycles.
        manual = 1'b1; ready = 1'b0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (c == 100) begin
                req_adr[1*ADR_W +: ADR_W] = 8'h55;
                req = 4'b0010;
            end else begin
                req = '0;
            end
            step();
        end
        req = '0;
        check("startup_no_intr", 32'(intr), 32'd0);
        ready = 1'b1;
        step();
        check("startup_intr", 32'(intr), 32'd1);
        check("startup_grant", 32'(grant), 32'b0010);
        check("startup_iadr", 32'(i_adr), 32'h55);
        ready = 1'b0;
        repeat (4) step();
        ready = 1'b1;
        step();
        check("startup_done", 32'(done), 32'b0010);
        step();

        // Request held across its own grant edge.
        gorder.delete();
        req_adr[3*ADR_W +: ADR_W] = 8'h33;
        req = 4'b1000;
        step();
        req_adr[3*ADR_W +: ADR_W] = 8'h34;
        step();
        req = '0;
        check("same_grant1", 32'(grant), 32'b1000);
        check("same_iadr1", 32'(i_adr), 32'h33);
        ready = 1'b0;
        repeat (3) step();
        ready = 1'b1;
        step();
        check("same_done1", 32'(done), 32'b1000);
        step();
        check("same_grant2", 32'(grant), 32'b1000);
        check("same_iadr2", 32'(i_adr), 32'h34);
        ready = 1'b0;
        step();
        ready = 1'b1;
        step();
        check("same_done2", 32'(done), 32'b1000);
        step();
        check("same_no_third", 32'(grant), 32'd0);
        check("same_count", 32'(gorder.size()), 32'd2);

        // Reset while a routine runs.
        req_adr[0 +: ADR_W] = 8'h70;
        req = 4'b0001;
        step();
        req = '0;
        step();
        check("rrun_grant", 32'(grant), 32'b0001);
        ready = 1'b0;
        repeat (2) step();
        check("rrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rrun_intr", 32'(intr), 32'd0);
        check("rrun_iadr", 32'(i_adr), 32'd0);
        check("rrun_grant0", 32'(grant), 32'd0);
        check("rrun_done0", 32'(done), 32'd0);
        check("rrun_busy0", 32'(busy), 32'd0);
        check("rrun_err0", 32'(err), 32'd0);
        done_seen = '0;
        repeat (4) begin step(); done_seen |= done; end
        ready = 1'b1;
        repeat (6) begin step(); done_seen |= done; end
        check("rrun_no_done", 32'(done_seen), 32'd0);

        // Interpreter never jumps: ready held high after issue.
        req_adr[1*ADR_W +: ADR_W] = 8'h66;
        req = 4'b0010;
        step();
        req = '0;
        step();
        check("wd_grant", 32'(grant), 32'b0010);
        repeat (WD - 1) step();
        check("wd_intr_before", 32'(intr), 32'd1);
        step();
`ifdef OLED_ARB_WATCHDOG_EN
        check("wd_intr_abort", 32'(intr), 32'd0);
        check("wd_err", 32'(err), 32'd1);
        check("wd_done", 32'(done), 32'b0010);
        check("wd_busy", 32'(busy), 32'd0);
        step();
        check("wd_err_pulse", 32'(err), 32'd0);
`else
        check("wd_intr_held", 32'(intr), 32'd1);
        check("wd_err_tied", 32'(err), 32'd0);
        check("wd_no_done", 32'(done), 32'd0);
        ready = 1'b0;
        step();
        ready = 1'b1;
        step();
        check("wd_late_done", 32'(done), 32'b0010);
        step();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        manual = 1'b0; ready = 1'b1; jump_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5, 0) == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    req[i] = ($urandom_range(1, 0) == 1);
                    req_adr[i*ADR_W +: ADR_W] = 8'($urandom);
                end
            end else begin
                req = '0;
            end
            step();
        end
        req = '0;
        drain("rand_drain", 5000);
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_intr_arbiter.md
# oled_intr_arbiter

Round-robin arbiter that shares the OLED command interpreter's interrupt entry (`intr`/`i_adr`) among several requesters. Each requester pulses a request with the program-memory address of its command routine. The block queues the request and launches it when the interpreter is idle (`ready` high at a NULL command). It then tracks the routine to completion and reports grant and done per requester. It sits between the application logic (button or game FSMs) and the interpreter.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ADR_W`, 8: routine address width; matches interpreter `p_adr`.
- `WD_CYCLES`, 1024: watchdog limit in cycles; used only with `OLED_ARB_WATCHDOG_EN`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: per-requester request pulse; level also accepted, each high cycle counts as a request.
- `req_adr` in NREQ*ADR_W: routine address; slice i is `req_adr[i*ADR_W +: ADR_W]`, sampled when `req[i]` is high.
- `ready` in 1: from interpreter; high = idle at NULL command.
- `intr` out 1: to interpreter `intr`.
- `i_adr` out ADR_W: to interpreter `i_adr`.
- `grant` out NREQ: one-hot, 1-cycle pulse when requester's routine is launched.
- `done` out NREQ: one-hot, 1-cycle pulse when launched routine has finished.
- `busy` out 1: high in ISSUE or RUN.
- `err` out 1: 1-cycle pulse on watchdog abort. Tied 0 without `OLED_ARB_WATCHDOG_EN`.

## Operation
- Per-requester `pending[i]` bit and `adr_q[i]` register.
  - `req[i]` high sets `pending[i]` and loads `adr_q[i]` from `req_adr` slice i.
  - A request while already pending overwrites `adr_q[i]`; requests are not counted or queued deeper.
- Round-robin pointer `last`, reset to NREQ-1. Winner is the first pending index searching `last+1, last+2, …` with modulo NREQ wrap.
- State IDLE:
  - Transition: if `ready`==1 and any `pending`, go to ISSUE.
  - On that edge: `i_adr`<=`adr_q[w]`, `intr`<=1, `grant[w]`<=1, `pending[w]`<=0, `last`<=w, `cur`<=w.
  - If `req[w]` is high on the same edge, set wins: `pending[w]` stays 1 with the new address.
- State ISSUE: hold `intr`=1 and `i_adr` stable while `ready`==1. When `ready`==0 is sampled (interpreter jumped), set `intr`<=0 and go to RUN.
- State RUN: wait for `ready`==1 (routine reached its terminating NULL). Then `done[cur]`<=1 and go to IDLE. IDLE may issue again at the next edge.
- Interpreter startup: `ready` is low until the interpreter enters its command loop. Requests accumulate in `pending` and nothing is issued meanwhile.
- `ready` dropping while in IDLE (external activity) blocks issue; no error is raised.
- Reset mid-operation clears everything. An interpreter routine already in flight runs to completion unobserved; no `done` is produced for it.

## Timing
- Reset values: `intr`=0, `i_adr`=0, `grant`=0, `done`=0, `busy`=0, `err`=0, `pending`=0, state IDLE, `last`=NREQ-1, watchdog count 0.
- All outputs are registered.
- `req[i]` high at edge k sets pending at k. The earliest `intr`/`grant` is at edge k+1, given IDLE and `ready`=1.
- `intr` rise to fall: at least 1 cycle. `intr` falls on the edge after `ready`=0 is sampled.
- `done` is asserted on the edge where RUN samples `ready`=1.
- Minimum issue-to-issue spacing: `grant` edge + 1 (ISSUE) + routine length + 1 (IDLE).
- `busy`=1 from the `grant` edge through the `done` edge, exclusive of the `done` cycle.

## Configuration
- `OLED_ARB_WATCHDOG_EN` defined:
  - A counter runs during ISSUE and RUN and clears on each state change.
  - If it reaches WD_CYCLES: `intr`<=0, `err`<=1 for 1 cycle, `done[cur]`<=1, return to IDLE.
  - The counter width holds WD_CYCLES.
- Not defined: no counter; `err` tied 0; ISSUE and RUN wait indefinitely.

## Test plan
- Single request: `ready`=1, `req[2]` pulse with adr 0x40 → next edge `intr`=1, `i_adr`=0x40, `grant`=0100. Model drops `ready` 1 cycle later → `intr`=0. `ready` returns after 20 cycles → `done`=0100 for 1 cycle.
- Fairness: `req`=1111 in one cycle with distinct addresses → grants in order 0, 1, 2, 3, one per completed routine. A repeat `req[0]` during service of 1 → served after 3.
- Startup: `ready`=0 for 500 cycles while `req[1]` pulses → no `intr`. `ready` rises → `intr` the next edge.
- Same-edge re-request: `req[3]` held high across its grant edge → pending stays 1 and a second `grant[3]` follows its `done`.
- Reset in RUN: `rst` for 1 cycle → all outputs 0, `pending`=0. Late `ready` rise produces no `done`.
- Watchdog (macro on, WD_CYCLES=16): `ready` held 1 after issue → at cycle 16 `intr`=0, `err` and `done[cur]` pulse; macro off → `intr` stays high.
